apb_master_ctrl: RTL and testbench

- APB initiator side of the AHB-APB bridge.
- Accepts single read/write requests from the AHB-side request interface and decodes the address to one of three APB peripheral selects.
- Sequences the APB SETUP/ACCESS phases, then returns read data with a one-cycle response pulse.
- Drives the APB signals consumed by apb_interface, which is the peripheral-side model.

---
 rtl/apb_master_ctrl.sv | 144 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB initiator for the AHB-APB bridge: accepts single requests, decodes one of
// three peripheral selects, runs SETUP/ACCESS and returns a one-cycle response.
//
// state     | meaning
// ST_IDLE   | no transfer in flight, ready for a request
// ST_SETUP  | APB setup phase (psel driven, penable low), request input blocked
// ST_ACCESS | APB access phase (penable high), prdata captured at end of cycle
// ST_ERR    | decode miss, one-cycle error completion without any APB phase
module apb_master_ctrl #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [5:0]  SLV0_TAG = 6'h20,
  parameter logic [5:0]  SLV1_TAG = 6'h21,
  parameter logic [5:0]  SLV2_TAG = 6'h22
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              pwrite,
  output logic              penable,
  output logic [2:0]        psel,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR} state_e;

  localparam int TAG_LSB = ADDR_W - 6;

  state_e            state_q, state_d;
  logic [2:0]        psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [5:0] tag;
  logic [2:0] dec_sel;
  logic       accept;

  assign tag       = req_addr[ADDR_W-1:TAG_LSB];
  assign req_ready = (state_q != ST_SETUP);
  assign accept    = req_valid & req_ready;

  always_comb begin
    dec_sel = 3'b000;
    if (tag == SLV0_TAG)      dec_sel = 3'b001;
    else if (tag == SLV1_TAG) dec_sel = 3'b010;
    else if (tag == SLV2_TAG) dec_sel = 3'b100;
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = pwrite_q ? '0 : prdata;
      end
      ST_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
      ST_IDLE: ;
    endcase

    // IDLE, ACCESS and ERR share the same accept/next-transfer decision
    if (state_q != ST_SETUP) begin
      if (accept) begin
        paddr_d  = req_addr;
        pwrite_d = req_write;
        pwdata_d = req_wdata;
        if (dec_sel != 3'b000) begin
          state_d = ST_SETUP;
          psel_d  = dec_sel;
        end else begin
          state_d = ST_ERR;
          psel_d  = 3'b000;
        end
      end else begin
        state_d = ST_IDLE;
        psel_d  = 3'b000;
      end
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 3'b000;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: stimulus queues expected APB phases and
// responses with their cycle stamps; a negedge monitor pops and compares.
module tb_apb_master_ctrl;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  psel;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  apb_master_ctrl dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .pwrite    (pwrite),
    .penable   (penable),
    .psel      (psel),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
  );

  initial forever #5 Hclk = ~Hclk;

  // peripheral model: read data only while penable is high
  function automatic logic [31:0] periph(input logic en, input logic [31:0] a);
    if (!en) return 32'h0;
    case (a)
      32'h8800_0004: return 32'h0000_00A5;
      32'h8400_0000: return 32'h1234_5678;
      default:       return {16'hCAFE, a[15:0]};
    endcase
  endfunction

  assign prdata = periph(penable, paddr);

  typedef struct {
    logic [2:0]  psel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          cyc;
  } apb_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_exp_t;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];
  apb_exp_t cur;
  rsp_exp_t rcur;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit done    = 1'b0;
  bit stim_to = 1'b0;

  always @(posedge Hclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge Hclk) begin
    if (!Hresetn) begin
      chk("rst_psel",      64'(psel),      64'd0);
      chk("rst_penable",   64'(penable),   64'd0);
      chk("rst_pwrite",    64'(pwrite),    64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err",   64'(rsp_err),   64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_paddr",     64'(paddr),     64'd0);
      chk("rst_pwdata",    64'(pwdata),    64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    end else begin
      if (psel != 3'b000 && !penable) begin
        chk("setup_req_ready", 64'(req_ready), 64'd0);
        if (apb_q.size() == 0) begin
          chk("setup_unexpected_psel", 64'(psel), 64'd0);
        end else begin
          cur = apb_q.pop_front();
          chk("setup_psel",   64'(psel),   64'(cur.psel));
          chk("setup_paddr",  64'(paddr),  64'(cur.addr));
          chk("setup_pwrite", 64'(pwrite), 64'(cur.wr));
          chk("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
          chk("setup_cycle",  64'(cyc),    64'(cur.cyc));
        end
      end
      if (penable) begin
        chk("access_psel",      64'(psel),      64'(cur.psel));
        chk("access_paddr",     64'(paddr),     64'(cur.addr));
        chk("access_pwrite",    64'(pwrite),    64'(cur.wr));
        chk("access_pwdata",    64'(pwdata),    64'(cur.wdata));
        chk("access_cycle",     64'(cyc),       64'(cur.cyc + 1));
        chk("access_req_ready", 64'(req_ready), 64'd1);
      end
      if (psel == 3'b000) begin
        chk("nosel_penable",   64'(penable),   64'd0);
        chk("nosel_req_ready", 64'(req_ready), 64'd1);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          rcur = rsp_q.pop_front();
          chk("rsp_err",   64'(rsp_err),   64'(rcur.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(rcur.rdata));
          chk("rsp_cycle", 64'(cyc),       64'(rcur.cyc));
        end
      end
    end
    if (done) begin
      chk("apb_left",     64'(apb_q.size()), 64'd0);
      chk("rsp_left",     64'(rsp_q.size()), 64'd0);
      chk("stim_timeout", 64'(stim_to),      64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    if (cyc > 3000) begin
      n_fail++;
      $display("FAIL global_timeout: reached cycle %0d, required done by 3000", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Present a request (held until accepted) and queue its expectations.
  // exp_psel == 0 means a decode miss.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] exp_psel, input logic [31:0] exp_rdata,
                        input bit push_rsp);
    int       a;
    bit       ok;
    apb_exp_t ae;
    rsp_exp_t re;
    ok = 1'b0;
    @(negedge Hclk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        @(posedge Hclk);
        ok = 1'b1;
        break;
      end
      @(negedge Hclk);
    end
    if (!ok) begin
      stim_to   = 1'b1;
      req_valid = 1'b0;
      return;
    end
    #1;
    a = cyc;
    if (exp_psel != 3'b000) begin
      ae.psel  = exp_psel;
      ae.addr  = addr;
      ae.wr    = wr;
      ae.wdata = wdata;
      ae.cyc   = a;
      apb_q.push_back(ae);
    end
    if (push_rsp) begin
      re.err   = (exp_psel == 3'b000);
      re.rdata = exp_rdata;
      re.cyc   = (exp_psel == 3'b000) ? a + 1 : a + 2;
      rsp_q.push_back(re);
    end
  endtask

  task automatic idle(input int n);
    @(negedge Hclk);
    req_valid = 1'b0;
    repeat (n - 1) @(negedge Hclk);
  endtask

  initial begin
    repeat (3) @(negedge Hclk);
    #2 Hresetn = 1'b1;
    idle(2);

    // single write to slave 0
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b001, 32'h0, 1'b1);
    idle(4);
    // single read from slave 2
    do_req(1'b0, 32'h8800_0004, 32'h0,         3'b100, 32'h0000_00A5, 1'b1);
    idle(4);
    // back-to-back: read slave 1, then write slave 0 held through SETUP
    do_req(1'b0, 32'h8400_0000, 32'h0,         3'b010, 32'h1234_5678, 1'b1);
    do_req(1'b1, 32'h8000_0008, 32'h0BAD_F00D, 3'b001, 32'h0, 1'b1);
    idle(4);
    // decode miss
    do_req(1'b1, 32'h9000_0000, 32'h0000_0055, 3'b000, 32'h0, 1'b1);
    idle(4);
    // miss followed directly by a hit accepted in ERR
    do_req(1'b0, 32'h0000_0000, 32'h0,         3'b000, 32'h0, 1'b1);
    do_req(1'b1, 32'h8800_0100, 32'h7777_1111, 3'b100, 32'h0, 1'b1);
    idle(4);
    // hit followed directly by a miss accepted in ACCESS
    do_req(1'b0, 32'h8400_0040, 32'h0,         3'b010, 32'hCAFE_0040, 1'b1);
    do_req(1'b0, 32'hFC00_0000, 32'h0,         3'b000, 32'h0, 1'b1);
    idle(4);

    // reset during ACCESS: no response expected for the aborted read
    do_req(1'b0, 32'h8000_0020, 32'h0,         3'b001, 32'h0, 1'b0);
    @(posedge Hclk);
    #2;
    Hresetn   = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge Hclk);
    #2 Hresetn = 1'b1;
    idle(5);

    // recovery transfer after reset
    do_req(1'b0, 32'h8000_0004, 32'h0,         3'b001, 32'hCAFE_0004, 1'b1);
    idle(5);
    done = 1'b1;
  end

endmodule
